pipe_ctrl_unit: RTL and testbench



---
 rtl/pipe_ctrl_unit_if.sv | 46 ++++
 rtl/pipe_ctrl_unit.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - hazard/redirect signal bundle between datapath and pipeline controller
interface pipe_ctrl_unit_if #(
    parameter int NSTAGE = 5,
    parameter int AW     = 32
);
    logic [NSTAGE-1:0] stall_req;
    logic              exc_valid;
    logic              exc_is_int;
    logic              exc_is_eret;
    logic [AW-1:0]     epc;
    logic              mem_busy;
    logic              br_mispredict;
    logic [AW-1:0]     br_target;
    logic              id_jmp;
    logic [AW-1:0]     jmp_target;
    logic              bp_taken;
    logic [AW-1:0]     bp_target;
    logic              ex_is_load;
    logic [4:0]        ex_rd;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;

    logic [NSTAGE-1:0] stage_stall;
    logic [NSTAGE-1:0] stage_flush;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic [2:0]        redirect_src;
    logic              except_handle;
    logic              stall_timeout;

    modport master (
        output stall_req, exc_valid, exc_is_int, exc_is_eret, epc, mem_busy,
               br_mispredict, br_target, id_jmp, jmp_target, bp_taken, bp_target,
               ex_is_load, ex_rd, id_rs, id_rt,
        input  stage_stall, stage_flush, redirect_valid, redirect_pc, redirect_src,
               except_handle, stall_timeout
    );

    modport slave (
        input  stall_req, exc_valid, exc_is_int, exc_is_eret, epc, mem_busy,
               br_mispredict, br_target, id_jmp, jmp_target, bp_taken, bp_target,
               ex_is_load, ex_rd, id_rs, id_rt,
        output stage_stall, stage_flush, redirect_valid, redirect_pc, redirect_src,
               except_handle, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline stall/flush, PC redirect, exception FSM and stall watchdog
module pipe_ctrl_unit #(
    parameter int             NSTAGE       = 5,
    parameter int             COMMIT_STAGE = 3,
    parameter int             BR_STAGE     = 3,
    parameter int             LU_BUBBLES   = 1,
    parameter int             DRAIN_MAX    = 16,
    parameter int             WDOG_MAX     = 1024,
    parameter int             AW           = 32,
    parameter logic [AW-1:0]  EXC_VECTOR   = 32'hBFC00380
) (
    input  logic               i_clk,
    input  logic               i_reset,
    pipe_ctrl_unit_if.slave    bus
);

    localparam int LW = (LU_BUBBLES > 0) ? $clog2(LU_BUBBLES + 1) : 1;
    localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam int WW = (WDOG_MAX > 0) ? $clog2(WDOG_MAX + 1) : 1;

    function automatic logic [NSTAGE-1:0] range_mask(input int lo, input int hi);
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NSTAGE-1:0] M_ALL        = '1;
    localparam logic [NSTAGE-1:0] M_TAKE_FLUSH = range_mask(1, COMMIT_STAGE);
    localparam logic [NSTAGE-1:0] M_TAKE_STALL = range_mask(COMMIT_STAGE + 1, COMMIT_STAGE + 1);
    localparam logic [NSTAGE-1:0] M_MISP_FLUSH = range_mask(1, BR_STAGE - 1);
    localparam logic [NSTAGE-1:0] M_BUB_STALL  = range_mask(0, 1);
    localparam logic [NSTAGE-1:0] M_BUB_FLUSH  = range_mask(2, 2);
    localparam logic [NSTAGE-1:0] M_DRN_STALL  = range_mask(0, 0);
    localparam logic [NSTAGE-1:0] M_DRN_FLUSH  = range_mask(1, 1);

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_EXC  = 3'd1;
    localparam logic [2:0] SRC_ERET = 3'd2;
    localparam logic [2:0] SRC_MISP = 3'd3;
    localparam logic [2:0] SRC_JMP  = 3'd4;
    localparam logic [2:0] SRC_BP   = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TAKE} state_t;

    state_t            r_state;
    logic [LW-1:0]     r_lu_cnt;
    logic [DW-1:0]     r_drain_cnt;
    logic [WW-1:0]     r_wdog_cnt;
    logic              r_timeout;

    state_t            w_state_nxt;
    logic [LW-1:0]     w_lu_nxt;
    logic [DW-1:0]     w_drain_nxt;
    logic [WW-1:0]     w_wdog_nxt;
    logic              w_wdog_hit;
    logic              w_hazard;
    logic [NSTAGE-1:0] w_req_stall;
    logic [NSTAGE-1:0] w_req_flush;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_flush;
    logic              w_rv;
    logic [AW-1:0]     w_rpc;
    logic [2:0]        w_rsrc;
    logic              w_exh;

    assign w_hazard = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt));

    // Last set bit wins in the scan, so the mask follows the highest requesting stage.
    always_comb begin
        w_req_stall = '0;
        w_req_flush = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (bus.stall_req[i]) begin
                w_req_stall = range_mask(0, i);
                w_req_flush = range_mask(i + 1, i + 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lu_nxt    = r_lu_cnt;
        w_drain_nxt = r_drain_cnt;
        w_stall     = '0;
        w_flush     = '0;
        w_rv        = 1'b0;
        w_rpc       = '0;
        w_rsrc      = SRC_SEQ;
        w_exh       = 1'b0;

        case (r_state)
            S_TAKE: begin
                w_rv        = 1'b1;
                w_exh       = 1'b1;
                w_flush     = M_TAKE_FLUSH;
                w_stall     = M_TAKE_STALL;
                w_lu_nxt    = '0;
                w_state_nxt = S_IDLE;
                if (bus.exc_is_eret) begin
                    w_rpc  = bus.epc;
                    w_rsrc = SRC_ERET;
                end else begin
                    w_rpc  = EXC_VECTOR;
                    w_rsrc = SRC_EXC;
                end
            end
            S_DRAIN: begin
                w_stall  = M_DRN_STALL;
                w_flush  = M_DRN_FLUSH;
                w_lu_nxt = '0;
                if (!bus.exc_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (!bus.mem_busy || r_drain_cnt == DW'(DRAIN_MAX - 1)) begin
                    w_state_nxt = S_TAKE;
                end else begin
                    w_drain_nxt = r_drain_cnt + 1'b1;
                end
            end
            default: begin
                if (|bus.stall_req) begin
                    w_stall  = w_req_stall;
                    w_flush  = w_req_flush;
                    w_lu_nxt = '0;
                end else if (bus.exc_valid) begin
                    w_lu_nxt = '0;
                    // Interrupts wait for the outstanding memory op; the front end keeps bubbling meanwhile.
                    if (bus.exc_is_int && bus.mem_busy) begin
                        w_stall     = M_DRN_STALL;
                        w_flush     = M_DRN_FLUSH;
                        w_drain_nxt = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_stall     = M_ALL;
                        w_state_nxt = S_TAKE;
                    end
                end else if (bus.br_mispredict) begin
                    w_rv     = 1'b1;
                    w_rpc    = bus.br_target;
                    w_rsrc   = SRC_MISP;
                    w_flush  = M_MISP_FLUSH;
                    w_lu_nxt = '0;
                end else if (bus.id_jmp) begin
                    w_rv     = 1'b1;
                    w_rpc    = bus.jmp_target;
                    w_rsrc   = SRC_JMP;
                    w_lu_nxt = '0;
                end else if (bus.bp_taken) begin
                    w_rv     = 1'b1;
                    w_rpc    = bus.bp_target;
                    w_rsrc   = SRC_BP;
                    w_lu_nxt = '0;
                end else if (r_lu_cnt != '0) begin
                    w_stall  = M_BUB_STALL;
                    w_flush  = M_BUB_FLUSH;
                    w_lu_nxt = r_lu_cnt - 1'b1;
                end else if (w_hazard) begin
                    // The detecting cycle is itself the first bubble.
                    w_stall  = M_BUB_STALL;
                    w_flush  = M_BUB_FLUSH;
                    w_lu_nxt = LW'(LU_BUBBLES - 1);
                end
            end
        endcase

        if (i_reset) begin
            w_stall = '0;
            w_flush = M_ALL;
            w_rv    = 1'b0;
            w_rpc   = '0;
            w_rsrc  = SRC_SEQ;
            w_exh   = 1'b0;
        end
    end

    always_comb begin
        w_wdog_nxt = '0;
        if (WDOG_MAX != 0 && |w_stall) begin
            w_wdog_nxt = (r_wdog_cnt == WW'(WDOG_MAX)) ? r_wdog_cnt : r_wdog_cnt + 1'b1;
        end
        w_wdog_hit = (WDOG_MAX != 0) && (w_wdog_nxt == WW'(WDOG_MAX));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_lu_cnt    <= '0;
            r_drain_cnt <= '0;
            r_wdog_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lu_cnt    <= w_lu_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_wdog_cnt  <= w_wdog_nxt;
            if (w_wdog_hit) r_timeout <= 1'b1;
        end
    end

    assign bus.stage_stall    = w_stall;
    assign bus.stage_flush    = w_flush;
    assign bus.redirect_valid = w_rv;
    assign bus.redirect_pc    = w_rpc;
    assign bus.redirect_src   = w_rsrc;
    assign bus.except_handle  = w_exh;
    assign bus.stall_timeout  = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit (vectors, corner sequences, random vs model)
module tb_pipe_ctrl_unit;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] BT      = 32'h1000_0040;
    localparam logic [31:0] JT      = 32'h2000_0080;
    localparam logic [31:0] PT      = 32'h3000_00C0;
    localparam int          LU      = 2;
    localparam int          DMAX    = 16;
    localparam int          WMAX    = 1024;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.NSTAGE(5), .AW(32)) u_if ();
    pipe_ctrl_unit #(.LU_BUBBLES(LU)) u_dut (.i_clk(clk), .i_reset(reset), .bus(u_if));

    typedef struct {
        logic [4:0]  req;
        logic        exc, misp, jmp, bp, load;
        logic [4:0]  rd, rs;
        logic [4:0]  x_stall, x_flush;
        logic        x_rv;
        logic [2:0]  x_src;
        logic [31:0] x_pc;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic [4:0] st, input logic [4:0] fl,
                              input logic rv, input logic [2:0] src, input logic [31:0] pc, input logic eh);
        chk(nm, {u_if.stage_stall, u_if.stage_flush, u_if.redirect_valid, u_if.redirect_src,
                 u_if.redirect_pc, u_if.except_handle}, {st, fl, rv, src, pc, eh});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        u_if.stall_req = '0; u_if.exc_valid = 0; u_if.exc_is_int = 0; u_if.exc_is_eret = 0;
        u_if.mem_busy = 0; u_if.br_mispredict = 0; u_if.id_jmp = 0; u_if.bp_taken = 0;
        u_if.ex_is_load = 0; u_if.ex_rd = '0; u_if.id_rs = '0; u_if.id_rt = '0;
    endtask

    // Reference model: mode flags plus counts of cycles spent draining / bubbles owed / stall run.
    logic        m_take, m_drn, m_to, n_take, n_drn, n_to;
    int          m_drained, m_bub, m_run, n_drained, n_bub, n_run;
    logic [4:0]  e_st, e_fl;
    logic        e_rv, e_eh;
    logic [2:0]  e_src;
    logic [31:0] e_pc;

    task automatic model_eval();
        int   k;
        logic haz;
        e_st = 0; e_fl = 0; e_rv = 0; e_eh = 0; e_src = 0; e_pc = 0;
        n_take = 0; n_drn = 0; n_drained = 0; n_bub = m_bub;
        haz = u_if.ex_is_load && u_if.ex_rd != 0 && (u_if.ex_rd == u_if.id_rs || u_if.ex_rd == u_if.id_rt);
        if (m_take) begin
            e_rv = 1; e_eh = 1; e_fl = 5'b01110; e_st = 5'b10000; n_bub = 0;
            if (u_if.exc_is_eret) begin e_pc = u_if.epc; e_src = 2; end
            else begin e_pc = EXC_VEC; e_src = 1; end
        end else if (m_drn) begin
            e_st = 5'b00001; e_fl = 5'b00010; n_bub = 0;
            if (u_if.exc_valid) begin
                if (!u_if.mem_busy || m_drained + 1 == DMAX) n_take = 1;
                else begin n_drn = 1; n_drained = m_drained + 1; end
            end
        end else if (u_if.stall_req != 0) begin
            k = 0;
            for (int i = 0; i < 5; i++) if (u_if.stall_req[i]) k = i;
            e_st = 5'((1 << (k + 1)) - 1);
            if (k < 4) e_fl = 5'(1 << (k + 1));
            n_bub = 0;
        end else if (u_if.exc_valid) begin
            n_bub = 0;
            if (u_if.exc_is_int && u_if.mem_busy) begin
                e_st = 5'b00001; e_fl = 5'b00010; n_drn = 1; n_drained = 0;
            end else begin
                e_st = 5'b11111; n_take = 1;
            end
        end else if (u_if.br_mispredict) begin
            e_rv = 1; e_pc = u_if.br_target; e_src = 3; e_fl = 5'b00110; n_bub = 0;
        end else if (u_if.id_jmp) begin
            e_rv = 1; e_pc = u_if.jmp_target; e_src = 4; n_bub = 0;
        end else if (u_if.bp_taken) begin
            e_rv = 1; e_pc = u_if.bp_target; e_src = 5; n_bub = 0;
        end else if (m_bub > 0) begin
            e_st = 5'b00011; e_fl = 5'b00100; n_bub = m_bub - 1;
        end else if (haz) begin
            e_st = 5'b00011; e_fl = 5'b00100; n_bub = LU - 1;
        end
        n_run = (e_st != 0) ? ((m_run + 1 > WMAX) ? WMAX : m_run + 1) : 0;
        n_to  = m_to | (n_run >= WMAX);
    endtask

    task automatic model_commit();
        m_take = n_take; m_drn = n_drn; m_drained = n_drained;
        m_bub = n_bub; m_run = n_run; m_to = n_to;
    endtask

    initial begin
        int   n;
        logic prev_exc;

        vt[0]  = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0};
        vt[1]  = '{5'b01000, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 0, 0};
        vt[2]  = '{5'b00001, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0};
        vt[3]  = '{5'b10000, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0};
        vt[4]  = '{5'b00110, 0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0};
        vt[5]  = '{5'b01000, 1, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 0, 0};
        vt[6]  = '{5'b00000, 0, 1, 1, 1, 0, 0, 0, 5'b00000, 5'b00110, 1, 3, BT};
        vt[7]  = '{5'b00000, 0, 0, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 1, 4, JT};
        vt[8]  = '{5'b00000, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 5'b00000, 1, 5, PT};
        vt[9]  = '{5'b00010, 0, 0, 0, 0, 1, 7, 7, 5'b00011, 5'b00100, 0, 0, 0};
        vt[10] = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0};
        vt[11] = '{5'b00000, 0, 1, 0, 0, 1, 7, 7, 5'b00000, 5'b00110, 1, 3, BT};
        vt[12] = '{5'b00000, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0};

        set_idle();
        u_if.epc = 32'h8000_1234; u_if.br_target = BT; u_if.jmp_target = JT; u_if.bp_target = PT;

        reset = 1;
        #2; expect_out("reset_c0", 5'b00000, 5'b11111, 0, 0, 0, 0);
        tick();
        #2; expect_out("reset_c1", 5'b00000, 5'b11111, 0, 0, 0, 0);
        chk("reset_timeout", u_if.stall_timeout, 0);
        tick();
        reset = 0;
        #2; expect_out("post_reset_idle", 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 13; i++) begin
            u_if.stall_req = vt[i].req; u_if.exc_valid = vt[i].exc; u_if.br_mispredict = vt[i].misp;
            u_if.id_jmp = vt[i].jmp; u_if.bp_taken = vt[i].bp; u_if.ex_is_load = vt[i].load;
            u_if.ex_rd = vt[i].rd; u_if.id_rs = vt[i].rs;
            #2;
            expect_out($sformatf("vec%0d", i), vt[i].x_stall, vt[i].x_flush, vt[i].x_rv, vt[i].x_src, vt[i].x_pc, 0);
            tick();
        end
        set_idle();

        // Exception held under a stall: no freeze/TAKE until stall_req clears.
        u_if.stall_req = 5'b01000; u_if.exc_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #2; expect_out("exc_under_stall", 5'b01111, 5'b10000, 0, 0, 0, 0);
            tick();
        end
        u_if.stall_req = 0;
        #2; expect_out("exc_freeze", 5'b11111, 5'b00000, 0, 0, 0, 0);
        tick();
        #2; expect_out("exc_take", 5'b10000, 5'b01110, 1, 1, EXC_VEC, 1);
        tick();
        set_idle();
        #2; expect_out("exc_back_idle", 0, 0, 0, 0, 0, 0);
        tick();

        u_if.exc_valid = 1; u_if.exc_is_eret = 1;
        #2; expect_out("eret_freeze", 5'b11111, 5'b00000, 0, 0, 0, 0);
        tick();
        #2; expect_out("eret_take", 5'b10000, 5'b01110, 1, 2, 32'h8000_1234, 1);
        tick();
        set_idle();

        // Interrupt with mem_busy for 5 cycles, then released.
        u_if.exc_valid = 1; u_if.exc_is_int = 1; u_if.mem_busy = 1;
        for (int i = 0; i < 5; i++) begin
            #2; expect_out("drain_busy", 5'b00001, 5'b00010, 0, 0, 0, 0);
            tick();
        end
        u_if.mem_busy = 0;
        #2; expect_out("drain_last", 5'b00001, 5'b00010, 0, 0, 0, 0);
        tick();
        #2; expect_out("drain_take", 5'b10000, 5'b01110, 1, 1, EXC_VEC, 1);
        tick();
        set_idle();
        #2; tick();

        // mem_busy stuck: entry cycle plus DRAIN_MAX drain cycles, then forced TAKE.
        u_if.exc_valid = 1; u_if.exc_is_int = 1; u_if.mem_busy = 1;
        n = 0;
        #2;
        while (!u_if.redirect_valid && n < 40) begin
            chk("drain_hold", {u_if.stage_stall, u_if.stage_flush}, {5'b00001, 5'b00010});
            tick(); #2; n++;
        end
        chk("drain_max_cycles", n, DMAX + 1);
        expect_out("drain_max_take", 5'b10000, 5'b01110, 1, 1, EXC_VEC, 1);
        tick();
        set_idle();
        #2; tick();

        // Interrupt withdrawn mid-drain returns to IDLE without a TAKE.
        u_if.exc_valid = 1; u_if.exc_is_int = 1; u_if.mem_busy = 1;
        #2; tick(); #2; tick();
        u_if.exc_valid = 0;
        #2; expect_out("drain_abort", 5'b00001, 5'b00010, 0, 0, 0, 0);
        tick();
        #2; expect_out("drain_abort_idle", 0, 0, 0, 0, 0, 0);
        tick();
        set_idle();

        // Load-use: LU_BUBBLES bubbles from a single-cycle hazard.
        u_if.ex_is_load = 1; u_if.ex_rd = 7; u_if.id_rs = 7; u_if.id_rt = 3;
        #2; expect_out("lu_bubble1", 5'b00011, 5'b00100, 0, 0, 0, 0);
        tick();
        set_idle();
        #2; expect_out("lu_bubble2", 5'b00011, 5'b00100, 0, 0, 0, 0);
        tick();
        #2; expect_out("lu_done", 0, 0, 0, 0, 0, 0);
        tick();
        u_if.ex_is_load = 1; u_if.ex_rd = 0; u_if.id_rs = 0; u_if.id_rt = 0;
        for (int i = 0; i < 2; i++) begin
            #2; expect_out("lu_r0_ignored", 0, 0, 0, 0, 0, 0);
            tick();
        end
        u_if.ex_rd = 9; u_if.id_rt = 9;
        #2; expect_out("lu_rt_bubble", 5'b00011, 5'b00100, 0, 0, 0, 0);
        tick();
        set_idle();
        u_if.br_mispredict = 1;
        #2; expect_out("lu_cleared_by_misp", 0, 5'b00110, 1, 3, BT, 0);
        tick();
        set_idle();
        #2; expect_out("lu_cleared_idle", 0, 0, 0, 0, 0, 0);
        tick();

        // Randomized run against the reference model.
        m_take = 0; m_drn = 0; m_drained = 0; m_bub = 0; m_run = 0; m_to = 0;
        prev_exc = 0;
        for (int c = 0; c < 520; c++) begin
            if (c < 500) begin
                u_if.stall_req     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
                u_if.exc_valid     = prev_exc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
                u_if.exc_is_int    = $urandom_range(0, 1);
                u_if.exc_is_eret   = ($urandom_range(0, 3) == 0);
                u_if.epc           = $urandom;
                u_if.mem_busy      = $urandom_range(0, 1);
                u_if.br_mispredict = ($urandom_range(0, 7) == 0);
                u_if.br_target     = $urandom;
                u_if.id_jmp        = ($urandom_range(0, 7) == 0);
                u_if.jmp_target    = $urandom;
                u_if.bp_taken      = ($urandom_range(0, 5) == 0);
                u_if.bp_target     = $urandom;
                u_if.ex_is_load    = ($urandom_range(0, 2) == 0);
                u_if.ex_rd         = 5'($urandom_range(0, 3));
                u_if.id_rs         = 5'($urandom_range(0, 3));
                u_if.id_rt         = 5'($urandom_range(0, 3));
                prev_exc           = u_if.exc_valid;
            end else begin
                set_idle();
            end
            #2;
            model_eval();
            chk($sformatf("rand_c%0d", c),
                {u_if.stage_stall, u_if.stage_flush, u_if.redirect_valid, u_if.redirect_src,
                 u_if.redirect_pc, u_if.except_handle, u_if.stall_timeout},
                {e_st, e_fl, e_rv, e_src, e_pc, e_eh, m_to});
            tick();
            model_commit();
        end
        set_idle();
        #2; tick();

        // Watchdog: 1024 consecutive stall cycles raise the sticky flag.
        u_if.stall_req = 5'b00001;
        for (int i = 0; i < WMAX; i++) begin
            #2;
            if (i == WMAX - 1) chk("wdog_before_limit", u_if.stall_timeout, 0);
            tick();
        end
        #2; chk("wdog_at_limit", u_if.stall_timeout, 1);
        tick();
        set_idle();
        for (int i = 0; i < 4; i++) tick();
        #2; chk("wdog_sticky", u_if.stall_timeout, 1);
        expect_out("wdog_idle_outputs", 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        tick();
        reset = 0;
        #2; chk("wdog_cleared_by_reset", u_if.stall_timeout, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
